// File: rtl/ysyx_24100005_imem_resp.sv
// Instruction-memory responder: one outstanding fetch, fixed-latency response,
// access-fault flagging, and a side load port for filling the array.
module ysyx_24100005_imem_resp #(
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [31:0]           addr_q;
    logic [31:0]           mem [DEPTH];

    logic [31:0]           src_addr_c;
    logic [31:0]           off_c;
    logic                  err_c;
    logic [DEPTH_LOG2-1:0] idx_c;

    // With LATENCY == 1 the response is registered on the acceptance edge, so
    // the live request address must be used instead of the latched copy.
    assign src_addr_c = (state == IDLE) ? req_addr : addr_q;
    assign off_c      = src_addr_c - BASE;
    assign err_c      = (off_c[1:0] != 2'b00) || ((off_c[31:2] >> DEPTH_LOG2) != 30'd0);
    assign idx_c      = off_c[DEPTH_LOG2+1:2];

    // Array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= err_c;
                            rsp_data  <= err_c ? 32'd0 : mem[idx_c];
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_c;
                        rsp_data  <= err_c ? 32'd0 : mem[idx_c];
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24100005_imem_resp.sv
// Randomized self-checking bench for ysyx_24100005_imem_resp against a
// word-array reference model; a second LATENCY=1 instance checks throughput.
module tb_ysyx_24100005_imem_resp;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          LAT  = 2;
    localparam int          NW   = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, rsp_err, ld_en = 1'b0;
    logic [31:0] req_addr = '0, rsp_data, ld_data = '0;
    logic [9:0]  ld_addr = '0;

    logic        req_valid1 = 1'b0, req_ready1, rsp_valid1, rsp_ready1 = 1'b0, rsp_err1, ld_en1 = 1'b0;
    logic [31:0] req_addr1 = '0, rsp_data1, ld_data1 = '0;
    logic [3:0]  ld_addr1 = '0;

    logic [31:0] ref_mem [NW];
    logic [31:0] ref_mem1 [16];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    ysyx_24100005_imem_resp #(.BASE(BASE), .DEPTH_LOG2(10), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    ysyx_24100005_imem_resp #(.BASE(BASE), .DEPTH_LOG2(4), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1), .rsp_err(rsp_err1),
        .ld_en(ld_en1), .ld_addr(ld_addr1), .ld_data(ld_data1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {err, data} from plain address arithmetic on the shadow array.
    function automatic logic [32:0] model(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        if ((off % 4) != 0 || off >= 32'(4 * NW)) return {1'b1, 32'd0};
        return {1'b0, ref_mem[off / 4]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One fetch; optional load on edge ldk after acceptance (0 = acceptance edge),
    // then 'stall' cycles of backpressure before the handshake.
    task automatic fetch(input logic [31:0] addr, input int ldk, input logic [9:0] lidx,
                         input logic [31:0] ldat, input int stall);
        logic [32:0] e;
        e = '0;
        chk("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        for (int k = 0; k < LAT; k++) begin
            if (k == ldk) begin
                ld_en = 1'b1; ld_addr = lidx; ld_data = ldat;
            end
            if (k == LAT - 1) e = model(addr);
            step();
            if (k == ldk) begin
                ref_mem[lidx] = ldat;
                ld_en = 1'b0;
            end
            if (k == 0) begin
                req_valid = 1'b0;
                req_addr  = $urandom;
            end
            if (k < LAT - 1) begin
                chk("wait_valid", 32'(rsp_valid), 32'd0);
                chk("wait_ready", 32'(req_ready), 32'd0);
            end
        end
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_ready_low", 32'(req_ready), 32'd0);
        chk("rsp_data", rsp_data, e[31:0]);
        chk("rsp_err", 32'(rsp_err), 32'(e[32]));
        for (int s = 0; s < stall; s++) begin
            rsp_ready = 1'b0;
            req_valid = 1'($urandom);
            step();
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_data", rsp_data, e[31:0]);
            chk("stall_err", 32'(rsp_err), 32'(e[32]));
        end
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("post_valid", 32'(rsp_valid), 32'd0);
        chk("post_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] off;
        int          r;
        int          ldk;
        logic [9:0]  li;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NW; i++) begin
            ld_en = 1'b1;
            ld_addr = 10'(i);
            ld_data = (i == 0) ? 32'h0010_0093 : (i == 1) ? 32'h0000_0073 : $urandom;
            if (i < 16) begin
                ld_en1 = 1'b1; ld_addr1 = 4'(i); ld_data1 = $urandom;
                ref_mem1[i] = ld_data1;
            end else begin
                ld_en1 = 1'b0;
            end
            ref_mem[i] = ld_data;
            step();
        end
        ld_en  = 1'b0;
        ld_en1 = 1'b0;

        // Directed fetches and address-fault boundaries.
        fetch(BASE,                     LAT, 10'd0, 32'd0, 0);
        fetch(BASE + 32'd4,             LAT, 10'd0, 32'd0, 0);
        chk("word1_ref", ref_mem[1], 32'h0000_0073);
        fetch(BASE + 32'd2,             LAT, 10'd0, 32'd0, 0);
        fetch(32'h7FFF_FFFC,            LAT, 10'd0, 32'd0, 0);
        fetch(BASE + 32'(4 * NW),       LAT, 10'd0, 32'd0, 0);
        fetch(BASE + 32'(4 * (NW - 1)), LAT, 10'd0, 32'd0, 0);
        fetch(BASE + 32'd8,             LAT, 10'd0, 32'd0, 5);

        // Load collisions: before the read edge is visible, on it is not.
        fetch(BASE + 32'd12, 0,       10'd3, 32'hDEAD_BEEF, 0);
        fetch(BASE + 32'd12, LAT - 1, 10'd3, 32'hCAFE_F00D, 0);
        fetch(BASE + 32'd12, LAT,     10'd0, 32'd0, 0);

        // Reset while waiting drops the transaction; memory is kept.
        req_valid = 1'b1;
        req_addr  = BASE + 32'd8;
        step();
        req_valid = 1'b0;
        chk("prerst_ready", 32'(req_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("asyrst_valid", 32'(rsp_valid), 32'd0);
        chk("asyrst_ready", 32'(req_ready), 32'd1);
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < LAT + 3; i++) begin
            step();
            chk("norsp_after_rst", 32'(rsp_valid), 32'd0);
        end
        rsp_ready = 1'b0;
        fetch(BASE + 32'd4, LAT, 10'd0, 32'd0, 0);

        // Randomized fetches with loads racing the read.
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                6:       a = BASE + 32'($urandom_range(0, 4 * NW - 1)) | 32'd1;
                7:       a = BASE - 32'($urandom_range(1, 1 << 20));
                8:       a = BASE + 32'(4 * NW) + 32'($urandom_range(0, 1 << 20));
                9:       a = $urandom;
                default: a = BASE + 32'(4 * $urandom_range(0, NW - 1));
            endcase
            off = a - BASE;
            li  = ($urandom_range(0, 1) == 1) ? off[11:2] : 10'($urandom);
            ldk = $urandom_range(0, LAT);
            fetch(a, ldk, li, $urandom, $urandom_range(0, 3));
        end

        // LATENCY=1 instance: back-to-back fetches every 2 cycles.
        rsp_ready1 = 1'b1;
        req_valid1 = 1'b1;
        begin
            int j;
            j = 0;
            for (int c = 0; c < 10; c++) begin
                if (c % 2 == 0) req_addr1 = BASE + 32'(4 * (j * 5 % 17));
                step();
                if (c % 2 == 0) begin
                    chk("l1_valid", 32'(rsp_valid1), 32'd1);
                    chk("l1_ready", 32'(req_ready1), 32'd0);
                    if ((j * 5 % 17) == 16) begin
                        chk("l1_err", 32'(rsp_err1), 32'd1);
                        chk("l1_data", rsp_data1, 32'd0);
                    end else begin
                        chk("l1_err", 32'(rsp_err1), 32'd0);
                        chk("l1_data", rsp_data1, ref_mem1[j * 5 % 17]);
                    end
                    j++;
                end else begin
                    chk("l1_gap_valid", 32'(rsp_valid1), 32'd0);
                    chk("l1_gap_ready", 32'(req_ready1), 32'd1);
                end
            end
        end
        req_valid1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
